// File: rtl/main.sv
// SAP-1 computer: 6-T-state fetch/execute over a hard-coded 16x8 program.
// Define MAIN_SEVENSEG_EN to build the seven-segment decoders for LED1/LED2.
module main (
  input  logic       clk,
  input  logic       clr,
  output logic [7:0] out,
  output logic [6:0] LED1,
  output logic [6:0] LED2
);

  localparam int unsigned AW = 4;
  localparam int unsigned DW = 8;

  localparam logic [3:0] OP_LDA = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_OUT = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  typedef enum logic [2:0] {
    T1 = 3'd0,
    T2 = 3'd1,
    T3 = 3'd2,
    T4 = 3'd3,
    T5 = 3'd4,
    T6 = 3'd5
  } tstate_e;

  tstate_e       state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [AW-1:0] mar_q, mar_d;
  logic [DW-1:0] ir_q, ir_d;
  logic [DW-1:0] a_q, a_d;
  logic [DW-1:0] b_q, b_d;
  logic [DW-1:0] out_q, out_d;
  logic          halt_q, halt_d;
  logic [DW-1:0] mem_rd;

  // Program ROM: LDA 9, ADD A, ADD B, SUB C, OUT, HLT plus its data words.
  function automatic logic [DW-1:0] rom(input logic [AW-1:0] addr);
    case (addr)
      4'h0:    rom = 8'h09;
      4'h1:    rom = 8'h1A;
      4'h2:    rom = 8'h1B;
      4'h3:    rom = 8'h2C;
      4'h4:    rom = 8'hE0;
      4'h5:    rom = 8'hF0;
      4'h9:    rom = 8'h10;
      4'hA:    rom = 8'h14;
      4'hB:    rom = 8'h18;
      4'hC:    rom = 8'h20;
      default: rom = 8'h00;
    endcase
  endfunction

  assign mem_rd = rom(mar_q);

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= T1;
      pc_q    <= '0;
      mar_q   <= '0;
      ir_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      out_q   <= '0;
      halt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      mar_q   <= mar_d;
      ir_q    <= ir_d;
      a_q     <= a_d;
      b_q     <= b_d;
      out_q   <= out_d;
      halt_q  <= halt_d;
    end
  end

  // Ring counter and per-T-state micro-operations; everything holds once halted.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    mar_d   = mar_q;
    ir_d    = ir_q;
    a_d     = a_q;
    b_d     = b_q;
    out_d   = out_q;
    halt_d  = halt_q;
    if (!halt_q) begin
      case (state_q)
        T1: begin
          mar_d   = pc_q;
          state_d = T2;
        end
        T2: begin
          pc_d    = pc_q + 4'd1;
          state_d = T3;
        end
        T3: begin
          ir_d    = mem_rd;
          state_d = T4;
        end
        T4: begin
          case (ir_q[7:4])
            OP_LDA, OP_ADD, OP_SUB: mar_d = ir_q[3:0];
            OP_OUT:                 out_d = a_q;
            OP_HLT:                 halt_d = 1'b1;
            default:                ;
          endcase
          state_d = T5;
        end
        T5: begin
          case (ir_q[7:4])
            OP_LDA:         a_d = mem_rd;
            OP_ADD, OP_SUB: b_d = mem_rd;
            default:        ;
          endcase
          state_d = T6;
        end
        T6: begin
          case (ir_q[7:4])
            OP_ADD:  a_d = a_q + b_q;
            OP_SUB:  a_d = a_q - b_q;
            default: ;
          endcase
          state_d = T1;
        end
        default: state_d = T1;
      endcase
    end
  end

  assign out = out_q;

`ifdef MAIN_SEVENSEG_EN
  // Active-low hex glyphs, bit0 = segment a .. bit6 = segment g.
  function automatic logic [6:0] seg7(input logic [3:0] nib);
    case (nib)
      4'h0:    seg7 = 7'b1000000;
      4'h1:    seg7 = 7'b1111001;
      4'h2:    seg7 = 7'b0100100;
      4'h3:    seg7 = 7'b0110000;
      4'h4:    seg7 = 7'b0011001;
      4'h5:    seg7 = 7'b0010010;
      4'h6:    seg7 = 7'b0000010;
      4'h7:    seg7 = 7'b1111000;
      4'h8:    seg7 = 7'b0000000;
      4'h9:    seg7 = 7'b0010000;
      4'hA:    seg7 = 7'b0001000;
      4'hB:    seg7 = 7'b0000011;
      4'hC:    seg7 = 7'b1000110;
      4'hD:    seg7 = 7'b0100001;
      4'hE:    seg7 = 7'b0000110;
      default: seg7 = 7'b0001110;
    endcase
  endfunction

  assign LED1 = seg7(out_q[7:4]);
  assign LED2 = seg7(out_q[3:0]);
`else
  assign LED1 = 7'b1111111;
  assign LED2 = 7'b1111111;
`endif

endmodule

// File: tb/tb_main.sv
// Directed bench for the SAP-1 main: reset, program timing, display, halt, resets.
module tb_main;

  logic       clk;
  logic       clr;
  logic [7:0] out;
  logic [6:0] LED1;
  logic [6:0] LED2;

  int n_checks;
  int n_errors;

`ifdef MAIN_SEVENSEG_EN
  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_C = 7'b1000110;
`else
  localparam logic [6:0] SEG_0 = 7'b1111111;
  localparam logic [6:0] SEG_1 = 7'b1111111;
  localparam logic [6:0] SEG_C = 7'b1111111;
`endif

  localparam logic [7:0] RESULT = 8'h1C;

  main dut (
    .clk  (clk),
    .clr  (clr),
    .out  (out),
    .LED1 (LED1),
    .LED2 (LED2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_display(input string tag, input logic [7:0] exp_out);
    check({tag, "_out"}, 32'(out), 32'(exp_out));
    check({tag, "_led1"}, 32'(LED1), (exp_out == RESULT) ? 32'(SEG_1) : 32'(SEG_0));
    check({tag, "_led2"}, 32'(LED2), (exp_out == RESULT) ? 32'(SEG_C) : 32'(SEG_0));
  endtask

  // Advance to the next rising edge and sample just after it.
  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    clr = 1'b0;

    for (int i = 0; i < 3; i++) step();
    check_display("reset", 8'h00);
    check("reset_pc", 32'(dut.pc_q), 32'd0);

    // Release between edges so the next rising edge is edge 1.
    @(negedge clk);
    clr = 1'b1;
    for (int e = 1; e <= 100; e++) begin
      step();
      if (e <= 40) check_display($sformatf("run_e%0d", e), (e >= 28) ? RESULT : 8'h00);
      if (e == 34 || e == 35 || e == 100) begin
        check($sformatf("halt_pc_e%0d", e), 32'(dut.pc_q), 32'd6);
        check($sformatf("halt_ring_e%0d", e), 32'(dut.state_q), 32'd4);
      end
    end
    check_display("halted_e100", RESULT);

    // Reset while halted clears out asynchronously.
    @(negedge clk);
    clr = 1'b0;
    #1;
    check_display("halt_reset", 8'h00);
    step();
    step();
    check_display("halt_reset_hold", 8'h00);
    check("halt_reset_ring", 32'(dut.state_q), 32'd0);
    @(negedge clk);
    clr = 1'b1;
    for (int e = 1; e <= 15; e++) step();
    check_display("rerun_e15", 8'h00);

    // Mid-run reset pulse at edge 15, then full rerun from address 0.
    clr = 1'b0;
    #1;
    check_display("mid_reset", 8'h00);
    check("mid_reset_pc", 32'(dut.pc_q), 32'd0);
    check("mid_reset_mar", 32'(dut.mar_q), 32'd0);
    @(negedge clk);
    clr = 1'b1;
    for (int e = 1; e <= 40; e++) begin
      step();
      if (e == 27) check_display("mid_e27", 8'h00);
      if (e == 28) check_display("mid_e28", RESULT);
      if (e == 40) check_display("mid_e40", RESULT);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/main.md
MAIN -- requirements
Module: main

Interface
REQ-001 SHALL have port clk, input, 1 bit: single system clock; all state updates on the rising edge.
REQ-002 SHALL have port clr, input, 1 bit: reset, asynchronous and active-low.
REQ-003 SHALL have port out, output, 8 bits: the output register, loaded only by the OUT instruction.
REQ-004 SHALL have port LED1, output, 7 bits: seven-segment pattern for out[7:4].
REQ-005 SHALL have port LED2, output, 7 bits: seven-segment pattern for out[3:0].

Function
REQ-006 SHALL implement an 8-bit SAP-1 computer with these state elements:
- 4-bit PC and 4-bit MAR.
- 8-bit IR, A (accumulator), B and OUT registers.
- Ring counter T1..T6.
- Halt flag.
- Internal 16x8 program memory.
REQ-007 SHALL decode opcodes from IR[7:4] and the operand address from IR[3:0]:
- LDA=0000, ADD=0001, SUB=0010, OUT=1110, HLT=1111.
- Any other opcode SHALL execute as a NOP.
REQ-008 SHALL hard-code the program memory as follows:
- Address 0: LDA 9 (0x09); 1: ADD A (0x1A); 2: ADD B (0x1B); 3: SUB C (0x2C); 4: OUT (0xE0); 5: HLT (0xF0).
- Data: 9=0x10, A=0x14, B=0x18, C=0x20.
- All other addresses SHALL hold 0x00.
REQ-009 SHALL execute every instruction in exactly 6 clock cycles; the ring counter advances one T-state per rising edge and wraps from T6 to T1.
REQ-010 SHALL perform these fetch actions for every opcode:
- T1: MAR<=PC.
- T2: PC<=PC+1, wrapping 15 to 0.
- T3: IR<=MEM[MAR].
REQ-011 SHALL perform these execute actions:
- LDA: T4 MAR<=IR[3:0]; T5 A<=MEM[MAR].
- ADD: T4 MAR<=IR[3:0]; T5 B<=MEM[MAR]; T6 A<=A+B.
- SUB: T4 MAR<=IR[3:0]; T5 B<=MEM[MAR]; T6 A<=A-B.
- OUT: T4 OUT<=A.
- HLT: T4 sets the halt flag.
- T-states with no listed action SHALL be idle.
REQ-012 SHALL compute ADD and SUB modulo 256 with no carry or flags; for example, 0x10-0x20 gives 0xF0.
REQ-013 SHALL freeze every register, including the ring counter, while the halt flag is set; only reset clears the halt flag.
REQ-014 SHALL drive out directly from the OUT register, so out changes only on an OUT T4 edge or on reset.
REQ-015 SHALL number edges from the first rising edge after clr deasserts (edge 1 = T1 of address 0), giving this timing for the built-in program:
- out becomes 0x1C at edge 28.
- Halt takes effect at edge 34.
- out stays 0x1C thereafter.
REQ-016 SHALL encode the segment outputs as follows:
- Bit order bit0=a through bit6=g.
- Segments are active-low.
- Hex glyphs 0-F: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.

Reset
REQ-017 SHALL, while clr=0, asynchronously force:
- PC, MAR, IR, A, B and OUT to 0x00.
- The ring counter to T1.
- The halt flag to clear.
REQ-018 SHALL hold out=0x00 and LED1=LED2=1000000 throughout reset.
REQ-019 SHALL, when reset is asserted mid-instruction or while halted, abort immediately and restart from address 0 after release, with the same timing as REQ-015.

Configuration
REQ-020 SHALL use macro MAIN_SEVENSEG_EN to control the display decoders:
- Defined: LED1 and LED2 decode per REQ-016.
- Undefined: the decoders are omitted and LED1=LED2=1111111 (all segments off) at all times.
- The CPU behaviour and out SHALL be identical in both builds.

Verification
REQ-021 Reset: hold clr=0 for 3 cycles -> out=0x00, LED1=LED2=1000000.
REQ-022 Program run: release clr -> out=0x00 through edge 27, then out=0x1C at edge 28.
REQ-023 Display: with out=0x1C -> LED1=1111001 ('1'), LED2=1000110 ('C').
REQ-024 Halt: run to edge 100 -> out remains 0x1C, and PC and ring counter are unchanged after edge 34.
REQ-025 Mid-run reset: pulse clr=0 at edge 15 -> out=0x00 immediately, then out=0x1C 28 edges after release.
REQ-026 Macro undefined: same stimulus -> out=0x1C at edge 28, LED1=LED2=1111111 throughout.
